// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns (active low,
// bit6..bit0 = centre..top) and the code type used by encoder and decoder.
`timescale 1ns/1ps
package seg7_pkg;

    typedef logic [4:0] code_t;

    localparam code_t BLANK_CODE = 5'd16;
    localparam code_t ERR_CODE   = 5'd31;

    localparam logic [6:0] PAT_0     = 7'b1000000;
    localparam logic [6:0] PAT_1     = 7'b1111001;
    localparam logic [6:0] PAT_2     = 7'b0100100;
    localparam logic [6:0] PAT_3     = 7'b0110000;
    localparam logic [6:0] PAT_4     = 7'b0011001;
    localparam logic [6:0] PAT_5     = 7'b0010010;
    localparam logic [6:0] PAT_6     = 7'b0000010;
    localparam logic [6:0] PAT_7     = 7'b1111000;
    localparam logic [6:0] PAT_8     = 7'b0000000;
    localparam logic [6:0] PAT_9     = 7'b0010000;
    localparam logic [6:0] PAT_A     = 7'b0001000;
    localparam logic [6:0] PAT_B     = 7'b0000011;
    localparam logic [6:0] PAT_C     = 7'b0100111;
    localparam logic [6:0] PAT_D     = 7'b0100001;
    localparam logic [6:0] PAT_E     = 7'b0000110;
    localparam logic [6:0] PAT_F     = 7'b0001110;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to code decoder.
// Ports: i_seg_n (7-bit active-low pattern) -> o_code (5-bit code).
`timescale 1ns/1ps
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg_n,
    output code_t      o_code
);

    always_comb begin
        o_code = ERR_CODE;
        case (i_seg_n)
            PAT_0:     o_code = 5'd0;
            PAT_1:     o_code = 5'd1;
            PAT_2:     o_code = 5'd2;
            PAT_3:     o_code = 5'd3;
            PAT_4:     o_code = 5'd4;
            PAT_5:     o_code = 5'd5;
            PAT_6:     o_code = 5'd6;
            PAT_7:     o_code = 5'd7;
            PAT_8:     o_code = 5'd8;
            PAT_9:     o_code = 5'd9;
            PAT_A:     o_code = 5'd10;
            PAT_B:     o_code = 5'd11;
            PAT_C:     o_code = 5'd12;
            PAT_D:     o_code = 5'd13;
            PAT_E:     o_code = 5'd14;
            PAT_F:     o_code = 5'd15;
            PAT_BLANK: o_code = BLANK_CODE;
            default:   o_code = ERR_CODE;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads a multiplexed active-low seven-segment bus back into digit codes.
// Ports: clk, reset (async high), seg_n[6:0], dig_n[N-1:0] in;
//        values[5N-1:0], frame_valid (pulse), frame_err out.
`timescale 1ns/1ps
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    output logic [5*NUM_DIGITS-1:0] values,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 2);

    logic [6:0]            r_seg_m, r_seg_s, r_seg_p;
    logic [NUM_DIGITS-1:0] r_dig_m, r_dig_s, r_dig_p;
    logic [CW-1:0]         r_cnt;
    logic [NUM_DIGITS-1:0] r_mask;
    code_t                 r_shadow [NUM_DIGITS];

    logic [NUM_DIGITS-1:0] w_low;
    logic                  w_onehot;
    logic                  w_same;
    logic                  w_capture;
    logic [NUM_DIGITS-1:0] w_mask_nx;
    logic                  w_publish;
    logic [CW-1:0]         w_cnt_nx;
    code_t                 w_code;
    logic [5*NUM_DIGITS-1:0] w_frame;
    logic                  w_err;

    seg7_pattern_decode u_dec (
        .i_seg_n (r_seg_s),
        .o_code  (w_code)
    );

    assign w_low    = ~r_dig_s;
    // Exactly one enable low: non-zero with a single set bit.
    assign w_onehot = (w_low != '0) &&
                      ((w_low & (w_low - NUM_DIGITS'(1))) == '0);
    assign w_same   = (r_seg_s == r_seg_p) && (r_dig_s == r_dig_p);
    // Fires only on the arm->max step, so a saturated dwell captures once.
    assign w_capture = w_onehot && w_same && (r_cnt == CNT_ARM);
    assign w_mask_nx = r_mask | w_low;
    assign w_publish = w_capture && (&w_mask_nx);

    always_comb begin
        w_cnt_nx = '0;
        if (w_onehot && w_same) begin
            w_cnt_nx = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
        end
    end

    // Frame as it will be published, bypassing the digit captured this edge.
    always_comb begin
        w_frame = '0;
        w_err   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_frame[5*i +: 5] = w_low[i] ? w_code : r_shadow[i];
            w_err = w_err | (w_frame[5*i +: 5] == ERR_CODE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg_m <= '1;
            r_seg_s <= '1;
            r_seg_p <= '1;
            r_dig_m <= '1;
            r_dig_s <= '1;
            r_dig_p <= '1;
            r_cnt   <= '0;
            r_mask  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= BLANK_CODE;
                values[5*i +: 5] <= BLANK_CODE;
            end
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_seg_m <= seg_n;
            r_seg_s <= r_seg_m;
            r_seg_p <= r_seg_s;
            r_dig_m <= dig_n;
            r_dig_s <= r_dig_m;
            r_dig_p <= r_dig_s;
            r_cnt   <= w_cnt_nx;
            frame_valid <= w_publish;
            if (w_capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_low[i]) r_shadow[i] <= w_code;
                end
                r_mask <= w_publish ? '0 : w_mask_nx;
            end
            if (w_publish) begin
                values    <= w_frame;
                frame_err <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder.
// Drives scanned digit patterns and checks published frames.
`timescale 1ns/1ps
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    localparam int ND = 4;
    localparam int SC = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [6:0]      seg_n;
    logic [ND-1:0]   dig_n;
    logic [5*ND-1:0] values;
    logic            frame_valid;
    logic            frame_err;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;

    localparam logic [6:0] PAT_BAD = 7'b0111111;
    localparam logic [19:0] ALL_BLANK = {4{5'd16}};

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .values      (values),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) fv_cnt++;

    function automatic logic [19:0] pack(input logic [4:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int d, input logic [6:0] pat, input int n);
        dig_n    = '1;
        dig_n[d] = 1'b0;
        seg_n    = pat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap();
        dig_n = '1;
        seg_n = 7'h7f;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int d, input logic [6:0] pat);
        show(d, pat, 12);
        gap();
    endtask

    initial begin
        reset = 1'b1;
        dig_n = '1;
        seg_n = 7'h7f;
        repeat (3) @(posedge clk);
        #1;
        check("rst_values", values, ALL_BLANK);
        check("rst_fv", frame_valid, 0);
        check("rst_ferr", frame_err, 0);
        reset = 1'b0;
        gap();

        // Normal frame, with exact latency on the completing digit.
        fv_cnt = 0;
        digit(0, PAT_1);
        digit(1, PAT_2);
        digit(2, PAT_3);
        check("no_early_fv", fv_cnt, 0);
        show(3, PAT_4, 9);
        check("lat_before", frame_valid, 0);
        show(3, PAT_4, 1);
        check("lat_pulse", frame_valid, 1);
        show(3, PAT_4, 1);
        check("lat_after", frame_valid, 0);
        show(3, PAT_4, 1);
        gap();
        check("norm_cnt", fv_cnt, 1);
        check("norm_values", values, pack(5'd1, 5'd2, 5'd3, 5'd4));
        check("norm_ferr", frame_err, 0);

        // Glitch: 7-cycle pattern must not be captured.
        fv_cnt = 0;
        show(0, PAT_8, 7);
        show(0, PAT_0, 10);
        gap();
        digit(1, PAT_5);
        digit(2, PAT_6);
        digit(3, PAT_7);
        check("glitch_cnt", fv_cnt, 1);
        check("glitch_d0", values[4:0], 0);
        check("glitch_values", values, pack(5'd0, 5'd5, 5'd6, 5'd7));

        // Unknown pattern then a clean frame.
        digit(0, PAT_0);
        digit(1, PAT_1);
        digit(2, PAT_BAD);
        digit(3, PAT_3);
        check("err_d2", values[14:10], 31);
        check("err_ferr", frame_err, 1);
        digit(3, PAT_9);
        digit(1, PAT_8);
        digit(2, PAT_7);
        digit(0, PAT_6);
        check("clean_values", values, pack(5'd6, 5'd8, 5'd7, 5'd9));
        check("clean_ferr", frame_err, 0);

        // Asynchronous reset mid-stream.
        show(0, PAT_5, 3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_values", values, ALL_BLANK);
        check("arst_fv", frame_valid, 0);
        check("arst_ferr", frame_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        gap();

        // Blank digit, then illegal enables must not capture.
        fv_cnt = 0;
        digit(0, PAT_8);
        digit(1, PAT_BLANK);
        digit(2, PAT_9);
        digit(3, PAT_A);
        check("blank_values", values, pack(5'd8, 5'd16, 5'd9, 5'd10));
        check("blank_ferr", frame_err, 0);
        fv_cnt = 0;
        dig_n = 4'b1100;
        seg_n = PAT_8;
        repeat (20) @(posedge clk);
        #1;
        gap();
        digit(2, PAT_C);
        digit(3, PAT_D);
        check("illegal_nofv", fv_cnt, 0);
        digit(0, PAT_E);
        digit(1, PAT_F);
        check("illegal_cnt", fv_cnt, 1);
        check("illegal_values", values, pack(5'd14, 5'd15, 5'd12, 5'd13));

        // Reset mid-frame discards partial captures.
        fv_cnt = 0;
        digit(0, PAT_1);
        digit(1, PAT_2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        gap();
        digit(2, PAT_3);
        digit(3, PAT_4);
        check("midrst_nofv", fv_cnt, 0);
        check("midrst_values", values, ALL_BLANK);
        digit(0, PAT_5);
        digit(1, PAT_6);
        check("midrst_cnt", fv_cnt, 1);
        check("midrst_values2", values, pack(5'd5, 5'd6, 5'd3, 5'd4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
